ac_alu_stage: RTL

AC_ALU_STAGE -- requirements
Module: ac_alu_stage

---
 rtl/ac_alu_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/ac_alu_stage.sv
// ac_alu_stage: three-state (IDLE/EXEC/WRITE) accumulator ALU stage feeding an AC register.
// In: CLK, CLR (async high), START, OP[3:0], AC_IN, DR_IN. Out: Data, LD, INC, E, BUSY, DONE, ERR.
module ac_alu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] AC_IN,
  input  logic [WIDTH-1:0] DR_IN,
  output logic [WIDTH-1:0] Data,
  output logic             LD,
  output logic             INC,
  output logic             E,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);
  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, d_q, d_d, data_q, data_d, res;
  logic e_op_q, e_op_d, e_q, e_d, ld_q, ld_d, inc_q, inc_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, e_nx, e_upd;
  always_comb begin
    res  = '0;
    e_nx = e_op_q;
    case (op_q)
      4'd0: res = a_q & d_q;
      4'd1: {e_nx, res} = {1'b0, a_q} + {1'b0, d_q};
      4'd2: res = d_q;
      4'd4: res = ~a_q;
      4'd5: {res, e_nx} = {e_op_q, a_q};
      4'd6: {e_nx, res} = {a_q, e_op_q};
      4'd8: e_nx = 1'b0;
      4'd9: e_nx = ~e_op_q;
      default: res = '0;
    endcase
  end
  assign e_upd = (op_q == 4'd1) | (op_q == 4'd5) | (op_q == 4'd6) | (op_q == 4'd8) | (op_q == 4'd9);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    d_d     = d_q;
    e_op_d  = e_op_q;
    data_d  = data_q;
    e_d     = e_q;
    busy_d  = busy_q;
    ld_d    = 1'b0;
    inc_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        state_d = EXEC;
        op_d    = OP;
        a_d     = AC_IN;
        d_d     = DR_IN;
        e_op_d  = e_q;
        busy_d  = 1'b1;
      end
      EXEC: begin
        state_d = WRITE;
        ld_d    = op_q <= 4'd6;
        inc_d   = op_q == 4'd7;
        err_d   = op_q > 4'd9;
        done_d  = 1'b1;
        data_d  = op_q <= 4'd6 ? res : data_q;
      end
      WRITE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        e_d     = e_upd ? e_nx : e_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      e_op_q  <= 1'b0;
      data_q  <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
      inc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      d_q     <= d_d;
      e_op_q  <= e_op_d;
      data_q  <= data_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      ld_q    <= ld_d;
      inc_q   <= inc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign Data = data_q;
  assign LD   = ld_q;
  assign INC  = inc_q;
  assign E    = e_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
endmodule
